dac_spi_arbiter: RTL and testbench

//  Owns the single DAC_SPI_Out serialiser and shares it between two requesters: the audio

---
 rtl/dac_pkg.sv | 24 ++
 rtl/dac_req_arbiter.sv | 40 ++++
 rtl/dac_spi_arbiter.sv | 125 ++++++++++++
 tb/tb_dac_spi_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC SPI arbiter: word width, channel command bytes,
// arbiter state encoding and the default power-up command words.
package dac_pkg;

    localparam int unsigned SPI_W = 24;

    localparam logic [7:0] CMD_CH_A = 8'h31;
    localparam logic [7:0] CMD_CH_B = 8'h32;

    localparam logic [SPI_W-1:0] INIT_CMD_0_DEF = 24'h380001;
    localparam logic [SPI_W-1:0] INIT_CMD_1_DEF = 24'h300003;

    // Bit positions within the one-hot winner vector
    localparam int unsigned WIN_AUDIO = 0;
    localparam int unsigned WIN_CTRL  = 1;

    typedef enum logic [1:0] {
        INIT_WAIT,
        INIT_HOLD,
        IDLE,
        HOLD
    } arb_state_t;

endpackage

// File: rtl/dac_req_arbiter.sv
// Audio-first priority between the two requesters, with a run counter that
// hands the next slot to control after MAX_AUDIO_RUN consecutive audio grants.
module dac_req_arbiter
    import dac_pkg::*;
#(
    parameter int unsigned MAX_AUDIO_RUN = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Audio_Req,
    input  logic       i_Ctrl_Req,
    input  logic       i_Grant,
    output logic [1:0] o_Winner
);

    localparam logic [3:0] RUN_MAX = 4'(MAX_AUDIO_RUN);

    logic [3:0] run_cnt;

    always_comb begin
        o_Winner = '0;
        if (i_Ctrl_Req && (!i_Audio_Req || run_cnt == RUN_MAX))
            o_Winner[WIN_CTRL] = 1'b1;
        else if (i_Audio_Req)
            o_Winner[WIN_AUDIO] = 1'b1;
    end

    // Only audio grants made while control is waiting extend the run
    always_ff @(posedge i_Clock) begin
        if (i_Reset)
            run_cnt <= '0;
        else if (i_Grant) begin
            if (o_Winner[WIN_CTRL] || !i_Ctrl_Req)
                run_cnt <= '0;
            else
                run_cnt <= run_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dac_spi_arbiter.sv
// Shares the DAC_SPI_Out serialiser between audio and control requesters after
// replaying the two-word DAC init sequence; flags sends whose Ready never fell.
module dac_spi_arbiter
    import dac_pkg::*;
#(
    parameter logic [SPI_W-1:0] INIT_CMD_0    = INIT_CMD_0_DEF,
    parameter logic [SPI_W-1:0] INIT_CMD_1    = INIT_CMD_1_DEF,
    parameter int unsigned      MAX_AUDIO_RUN = 4,
    parameter logic [7:0]       TIMEOUT       = 8'd255
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Audio_Req,
    input  logic [SPI_W-1:0] i_Audio_Data,
    output logic             o_Audio_Ack,
    input  logic             i_Ctrl_Req,
    input  logic [SPI_W-1:0] i_Ctrl_Data,
    output logic             o_Ctrl_Ack,
    input  logic             i_DAC_Ready,
    output logic [SPI_W-1:0] o_DAC_Data,
    output logic             o_DAC_Send,
    output logic             o_Init_Done,
    output logic             o_Error
);

    arb_state_t       state, state_n;
    logic             init_idx, init_idx_n;
    logic [SPI_W-1:0] data_n;
    logic             send_n, audio_ack_n, ctrl_ack_n, done_n, error_n;
    logic [7:0]       tmo_cnt, tmo_cnt_n;
    logic             grant, expired;
    logic [1:0]       winner;

    dac_req_arbiter #(
        .MAX_AUDIO_RUN (MAX_AUDIO_RUN)
    ) u_req_arbiter (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Audio_Req (i_Audio_Req),
        .i_Ctrl_Req  (i_Ctrl_Req),
        .i_Grant     (grant),
        .o_Winner    (winner)
    );

    assign expired = i_DAC_Ready && (tmo_cnt == TIMEOUT - 8'd1);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= INIT_WAIT;
            init_idx    <= 1'b0;
            o_DAC_Data  <= '0;
            o_DAC_Send  <= 1'b0;
            o_Audio_Ack <= 1'b0;
            o_Ctrl_Ack  <= 1'b0;
            o_Init_Done <= 1'b0;
            o_Error     <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_n;
            init_idx    <= init_idx_n;
            o_DAC_Data  <= data_n;
            o_DAC_Send  <= send_n;
            o_Audio_Ack <= audio_ack_n;
            o_Ctrl_Ack  <= ctrl_ack_n;
            o_Init_Done <= done_n;
            o_Error     <= error_n;
            tmo_cnt     <= tmo_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        init_idx_n  = init_idx;
        data_n      = o_DAC_Data;
        send_n      = o_DAC_Send;
        audio_ack_n = 1'b0;
        ctrl_ack_n  = 1'b0;
        done_n      = o_Init_Done;
        error_n     = o_Error;
        tmo_cnt_n   = tmo_cnt;
        grant       = 1'b0;

        case (state)
            INIT_WAIT: begin
                if (i_DAC_Ready) begin
                    data_n    = init_idx ? INIT_CMD_1 : INIT_CMD_0;
                    send_n    = 1'b1;
                    tmo_cnt_n = '0;
                    state_n   = INIT_HOLD;
                end
            end
            INIT_HOLD, HOLD: begin
                // A timed-out word is treated as sent; only the sticky flag records it
                if (!i_DAC_Ready || expired) begin
                    send_n = 1'b0;
                    if (expired)
                        error_n = 1'b1;
                    if (state == HOLD)
                        state_n = IDLE;
                    else if (init_idx) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        init_idx_n = 1'b1;
                        state_n    = INIT_WAIT;
                    end
                end else begin
                    tmo_cnt_n = tmo_cnt + 8'd1;
                end
            end
            IDLE: begin
                if (i_DAC_Ready && (winner != '0)) begin
                    grant       = 1'b1;
                    data_n      = winner[WIN_CTRL] ? i_Ctrl_Data : i_Audio_Data;
                    send_n      = 1'b1;
                    audio_ack_n = winner[WIN_AUDIO];
                    ctrl_ack_n  = winner[WIN_CTRL];
                    tmo_cnt_n   = '0;
                    state_n     = HOLD;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Directed scoreboard bench for dac_spi_arbiter with a DAC_SPI_Out Ready model
// and queue-fed requesters that hold Req until acknowledged.
module tb_dac_spi_arbiter;

    typedef struct packed {
        logic [23:0] data;
        logic [1:0]  ack;   // {ctrl, audio}
    } exp_t;

    localparam logic [1:0] ACK_NONE  = 2'b00;
    localparam logic [1:0] ACK_AUDIO = 2'b01;
    localparam logic [1:0] ACK_CTRL  = 2'b10;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        audio_req = 1'b0;
    logic [23:0] audio_data = '0;
    logic        ctrl_req = 1'b0;
    logic [23:0] ctrl_data = '0;
    logic        dac_ready = 1'b0;
    logic        o_Audio_Ack, o_Ctrl_Ack, o_DAC_Send, o_Init_Done, o_Error;
    logic [23:0] o_DAC_Data;

    int checks = 0;
    int errors = 0;
    int a_ack_cnt = 0;
    int n;

    logic        stuck = 1'b0;
    int          boot_cnt = 0;
    int          busy_cnt = 0;
    logic        prev_send = 1'b0;
    logic [23:0] held_data = '0;

    exp_t        exp_q[$];
    logic [23:0] a_src[$];
    logic [23:0] c_src[$];

    dac_spi_arbiter dut (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Audio_Req  (audio_req),
        .i_Audio_Data (audio_data),
        .o_Audio_Ack  (o_Audio_Ack),
        .i_Ctrl_Req   (ctrl_req),
        .i_Ctrl_Data  (ctrl_data),
        .o_Ctrl_Ack   (o_Ctrl_Ack),
        .i_DAC_Ready  (dac_ready),
        .o_DAC_Data   (o_DAC_Data),
        .o_DAC_Send   (o_DAC_Send),
        .o_Init_Done  (o_Init_Done),
        .o_Error      (o_Error)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_idle();
        return exp_q.size() == 0 && a_src.size() == 0 && c_src.size() == 0 &&
               !audio_req && !ctrl_req && !o_DAC_Send && dac_ready;
    endfunction

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (is_idle()) break;
            @(negedge i_Clock);
        end
        check(tag, 32'(is_idle()), 32'd1);
    endtask

    task automatic wait_send_rise(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (o_DAC_Send) break;
            @(negedge i_Clock);
        end
        check(tag, 32'(o_DAC_Send), 32'd1);
    endtask

    task automatic wait_init_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (o_Init_Done) break;
            @(negedge i_Clock);
        end
        check(tag, 32'(o_Init_Done), 32'd1);
    endtask

    // DAC_SPI_Out stand-in: boot delay, then Ready drops for a few cycles per Send
    always @(posedge i_Clock) begin
        if (i_Reset) begin
            dac_ready <= 1'b0;
            boot_cnt  <= 10;
            busy_cnt  <= 0;
        end else if (boot_cnt != 0) begin
            boot_cnt <= boot_cnt - 1;
            if (boot_cnt == 1) dac_ready <= 1'b1;
        end else if (dac_ready) begin
            if (o_DAC_Send && !stuck) begin
                dac_ready <= 1'b0;
                busy_cnt  <= 5;
            end
        end else if (busy_cnt <= 1) begin
            dac_ready <= 1'b1;
        end else begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Requesters: present the next queued word, hold until acked
    always @(negedge i_Clock) begin
        if (o_Audio_Ack || !audio_req) begin
            if (a_src.size() > 0) begin
                audio_req  <= 1'b1;
                audio_data <= a_src.pop_front();
            end else begin
                audio_req <= 1'b0;
            end
        end
        if (o_Ctrl_Ack || !ctrl_req) begin
            if (c_src.size() > 0) begin
                ctrl_req  <= 1'b1;
                ctrl_data <= c_src.pop_front();
            end else begin
                ctrl_req <= 1'b0;
            end
        end
    end

    // Output monitor: each Send rise must match the head of the scoreboard
    always @(negedge i_Clock) begin
        check("one_ack", 32'(o_Audio_Ack & o_Ctrl_Ack), 32'd0);
        if (o_Audio_Ack) a_ack_cnt <= a_ack_cnt + 1;
        if (!i_Reset) begin
            if (o_DAC_Send && !prev_send) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_send", 32'(o_DAC_Data), 32'hFFFFFFFF);
                end else begin
                    check("word", 32'(o_DAC_Data), 32'(exp_q[0].data));
                    check("ack", 32'({o_Ctrl_Ack, o_Audio_Ack}), 32'(exp_q[0].ack));
                    void'(exp_q.pop_front());
                end
                held_data <= o_DAC_Data;
            end
            if (!o_DAC_Send && prev_send)
                check("data_stable", 32'(o_DAC_Data), 32'(held_data));
        end
        prev_send <= o_DAC_Send;
    end

    initial begin
        // Reset state
        i_Reset = 1'b1;
        repeat (3) @(negedge i_Clock);
        check("rst_send", 32'(o_DAC_Send), 32'd0);
        check("rst_data", 32'(o_DAC_Data), 32'd0);
        check("rst_acks", 32'({o_Ctrl_Ack, o_Audio_Ack}), 32'd0);
        check("rst_done", 32'(o_Init_Done), 32'd0);
        check("rst_error", 32'(o_Error), 32'd0);

        // Init sequence, with an audio request pending throughout it
        exp_q.push_back('{24'h380001, ACK_NONE});
        exp_q.push_back('{24'h300003, ACK_NONE});
        exp_q.push_back('{24'h320100, ACK_AUDIO});
        a_src.push_back(24'h320100);
        @(negedge i_Clock);
        i_Reset = 1'b0;
        wait_init_done("init_done");
        check("no_ack_during_init", 32'(a_ack_cnt), 32'd0);
        check("init_words_sent", 32'(exp_q.size()), 32'd1);
        wait_idle("init_drain");

        // Single audio request: Ack and Send one cycle after Req
        @(posedge i_Clock);
        exp_q.push_back('{24'h31ABCD, ACK_AUDIO});
        a_src.push_back(24'h31ABCD);
        @(negedge i_Clock);
        @(negedge i_Clock);
        check("lat_ack", 32'(o_Audio_Ack), 32'd1);
        check("lat_send", 32'(o_DAC_Send), 32'd1);
        wait_idle("single_drain");

        // Audio held continuously with control pending: 4 audio, ctrl, audio resumes
        @(posedge i_Clock);
        for (int i = 0; i < 6; i++) a_src.push_back(24'h310000 + 24'(i));
        c_src.push_back(24'h200005);
        for (int i = 0; i < 4; i++) exp_q.push_back('{24'h310000 + 24'(i), ACK_AUDIO});
        exp_q.push_back('{24'h200005, ACK_CTRL});
        for (int i = 4; i < 6; i++) exp_q.push_back('{24'h310000 + 24'(i), ACK_AUDIO});
        wait_idle("starve_drain");

        // Run again: counter must have restarted, so again 4 audio before ctrl
        @(posedge i_Clock);
        for (int i = 0; i < 5; i++) a_src.push_back(24'h317700 + 24'(i));
        c_src.push_back(24'h200006);
        for (int i = 0; i < 4; i++) exp_q.push_back('{24'h317700 + 24'(i), ACK_AUDIO});
        exp_q.push_back('{24'h200006, ACK_CTRL});
        exp_q.push_back('{24'h317704, ACK_AUDIO});
        wait_idle("restart_drain");

        // Both requests rise together: audio first, ctrl second
        @(posedge i_Clock);
        a_src.push_back(24'h311111);
        c_src.push_back(24'h322222);
        exp_q.push_back('{24'h311111, ACK_AUDIO});
        exp_q.push_back('{24'h322222, ACK_CTRL});
        wait_idle("both_drain");

        // DAC never drops Ready: Send high for TIMEOUT cycles, sticky error
        @(negedge i_Clock);
        stuck = 1'b1;
        @(posedge i_Clock);
        a_src.push_back(24'h310F0F);
        exp_q.push_back('{24'h310F0F, ACK_AUDIO});
        @(negedge i_Clock);
        wait_send_rise("tmo_rise");
        n = 0;
        while (o_DAC_Send && n < 400) begin
            n++;
            @(negedge i_Clock);
        end
        check("tmo_len", 32'(n), 32'd255);
        check("tmo_error", 32'(o_Error), 32'd1);
        stuck = 1'b0;
        @(posedge i_Clock);
        c_src.push_back(24'h321234);
        exp_q.push_back('{24'h321234, ACK_CTRL});
        wait_idle("after_tmo_drain");
        check("error_sticky", 32'(o_Error), 32'd1);

        // Reset during HOLD abandons the word and replays init
        @(posedge i_Clock);
        a_src.push_back(24'h315555);
        exp_q.push_back('{24'h315555, ACK_AUDIO});
        @(negedge i_Clock);
        wait_send_rise("hold_rise");
        @(negedge i_Clock);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        check("rst_hold_send", 32'(o_DAC_Send), 32'd0);
        check("rst_hold_done", 32'(o_Init_Done), 32'd0);
        check("rst_hold_error", 32'(o_Error), 32'd0);
        check("rst_hold_data", 32'(o_DAC_Data), 32'd0);
        exp_q.push_back('{24'h380001, ACK_NONE});
        exp_q.push_back('{24'h300003, ACK_NONE});
        @(negedge i_Clock);
        i_Reset = 1'b0;
        wait_init_done("replay_done");
        wait_idle("replay_drain");
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
